// File: rtl/int_ack_sequencer_pkg.sv
// Shared types and defaults for the interrupt acknowledge sequencer.
package int_ack_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INTA,
    ST_PUSH,
    ST_VEC_LO,
    ST_VEC_HI,
    ST_LOAD
  } state_e;

  typedef enum logic [1:0] {
    OP_INTA  = 2'd0,
    OP_PUSH  = 2'd1,
    OP_MEMRD = 2'd2
  } bus_op_e;

  typedef enum logic [1:0] {
    IM_0 = 2'd0,
    IM_1 = 2'd1,
    IM_2 = 2'd2
  } im_mode_e;

  localparam logic [15:0] NMI_VEC_DEF = 16'h0066;
  localparam logic [15:0] IM1_VEC_DEF = 16'h0038;

  function automatic logic is_bus_state(input state_e s);
    return (s == ST_INTA) || (s == ST_PUSH) || (s == ST_VEC_LO) || (s == ST_VEC_HI);
  endfunction

endpackage

// File: rtl/int_ack_sequencer_iff_ctrl.sv
// Interrupt enable flip-flops, EI shadow and NMI falling-edge latch.
module int_ack_sequencer_iff_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic p2_ei,
  input  logic p2_di,
  input  logic p2_retn,
  input  logic insn_end,
  input  logic not_nmi,
  input  logic accept_nmi,
  input  logic accept_int,
  output logic iff1,
  output logic iff2,
  output logic ei_hold,
  output logic nmi_pending
);

  logic iff1_q, iff1_d;
  logic iff2_q, iff2_d;
  logic ei_hold_q, ei_hold_d;
  logic nmi_latch_q, nmi_latch_d;
  logic not_nmi_prev_q;

  always_comb begin
    iff1_d      = iff1_q;
    iff2_d      = iff2_q;
    ei_hold_d   = ei_hold_q;
    nmi_latch_d = nmi_latch_q;

    if (p2_di) begin
      iff1_d = 1'b0;
      iff2_d = 1'b0;
    end else if (p2_ei) begin
      iff1_d = 1'b1;
      iff2_d = 1'b1;
    end else if (p2_retn) begin
      iff1_d = iff2_q;
    end

    // The shadow is consumed by the first instruction boundary after EI.
    if (p2_ei && !p2_di) ei_hold_d = 1'b1;
    else if (insn_end)   ei_hold_d = 1'b0;

    if (accept_nmi) begin
      iff2_d = iff1_q;
      iff1_d = 1'b0;
    end else if (accept_int) begin
      iff1_d = 1'b0;
      iff2_d = 1'b0;
    end

    if (accept_nmi)                 nmi_latch_d = 1'b0;
    if (not_nmi_prev_q && !not_nmi) nmi_latch_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iff1_q         <= 1'b0;
      iff2_q         <= 1'b0;
      ei_hold_q      <= 1'b0;
      nmi_latch_q    <= 1'b0;
      not_nmi_prev_q <= 1'b1;
    end else begin
      iff1_q         <= iff1_d;
      iff2_q         <= iff2_d;
      ei_hold_q      <= ei_hold_d;
      nmi_latch_q    <= nmi_latch_d;
      not_nmi_prev_q <= not_nmi;
    end
  end

  assign iff1        = iff1_q;
  assign iff2        = iff2_q;
  assign ei_hold     = ei_hold_q;
  assign nmi_pending = nmi_latch_q;

endmodule

// File: rtl/int_ack_sequencer.sv
// Interrupt mode state, acceptance and NMI/IM0/IM1/IM2 acknowledge sequencing.
module int_ack_sequencer
  import int_ack_sequencer_pkg::*;
#(
  parameter logic [15:0] NMI_VEC = NMI_VEC_DEF,
  parameter logic [15:0] IM1_VEC = IM1_VEC_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        P2_IM0,
  input  logic        P2_IM1,
  input  logic        P2_IM2,
  input  logic        P2_EI,
  input  logic        P2_DI,
  input  logic        P2_RETN,
  input  logic        insn_end,
  input  logic        notINT,
  input  logic        notNMI,
  input  logic [7:0]  I_reg,
  input  logic [15:0] pc_cur,
  output logic        bus_req,
  output logic [1:0]  bus_op,
  output logic [15:0] bus_addr,
  input  logic        bus_done,
  input  logic [7:0]  bus_rdata,
  output logic        pc_load,
  output logic [15:0] pc_new,
  output logic        inj_valid,
  output logic [7:0]  inj_op,
  output logic        busy,
  output logic [1:0]  im_mode,
  output logic        iff1,
  output logic        iff2
);

  state_e     state_q, state_d;
  im_mode_e   im_mode_q, im_mode_d;
  im_mode_e   mode_q, mode_d;
  logic       nmi_q, nmi_d;
  logic [7:0] v_q, v_d;
  logic [7:0] lo_q, lo_d;
  logic [7:0] hi_q, hi_d;
  logic [15:0] target_q, target_d;
  logic       bus_req_q, bus_req_d;
  logic       inj_valid_q, inj_valid_d;
  logic [7:0] inj_op_q, inj_op_d;

  logic accept_nmi, accept_int;
  logic ei_hold, nmi_pending;
  logic use_vec;
  logic [15:0] vec_addr;

  // The bus unit takes the push data straight from pc_cur.
  logic unused_pc_cur;
  assign unused_pc_cur = ^pc_cur;

  int_ack_sequencer_iff_ctrl u_iff_ctrl (
    .clk         (CLK),
    .rst         (RESET),
    .p2_ei       (P2_EI),
    .p2_di       (P2_DI),
    .p2_retn     (P2_RETN),
    .insn_end    (insn_end),
    .not_nmi     (notNMI),
    .accept_nmi  (accept_nmi),
    .accept_int  (accept_int),
    .iff1        (iff1),
    .iff2        (iff2),
    .ei_hold     (ei_hold),
    .nmi_pending (nmi_pending)
  );

  assign use_vec  = !nmi_q && (mode_q == IM_2);
  assign vec_addr = {I_reg, v_q};

  always_comb begin
    state_d     = state_q;
    im_mode_d   = im_mode_q;
    mode_d      = mode_q;
    nmi_d       = nmi_q;
    v_d         = v_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    target_d    = target_q;
    inj_valid_d = 1'b0;
    inj_op_d    = inj_op_q;
    accept_nmi  = 1'b0;
    accept_int  = 1'b0;

    if (P2_IM2)      im_mode_d = IM_2;
    else if (P2_IM1) im_mode_d = IM_1;
    else if (P2_IM0) im_mode_d = IM_0;

    case (state_q)
      ST_IDLE: begin
        if (insn_end) begin
          if (nmi_pending) begin
            accept_nmi = 1'b1;
            nmi_d      = 1'b1;
            target_d   = NMI_VEC;
            state_d    = ST_PUSH;
          end else if (!notINT && iff1 && !ei_hold) begin
            accept_int = 1'b1;
            nmi_d      = 1'b0;
            mode_d     = im_mode_q;
            state_d    = ST_INTA;
          end
        end
      end
      ST_INTA: begin
        if (bus_done) begin
          case (mode_q)
            IM_0: begin
              inj_op_d    = bus_rdata;
              inj_valid_d = 1'b1;
              state_d     = ST_IDLE;
            end
            IM_1: begin
              target_d = IM1_VEC;
              state_d  = ST_PUSH;
            end
            default: begin
              v_d     = bus_rdata;
              state_d = ST_PUSH;
            end
          endcase
        end
      end
      ST_PUSH: begin
        if (bus_done) state_d = use_vec ? ST_VEC_LO : ST_LOAD;
      end
      ST_VEC_LO: begin
        if (bus_done) begin
          lo_d    = bus_rdata;
          state_d = ST_VEC_HI;
        end
      end
      ST_VEC_HI: begin
        if (bus_done) begin
          hi_d    = bus_rdata;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Registered request follows the state being entered.
    bus_req_d = is_bus_state(state_d);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      im_mode_q   <= IM_0;
      mode_q      <= IM_0;
      nmi_q       <= 1'b0;
      v_q         <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      target_q    <= '0;
      bus_req_q   <= 1'b0;
      inj_valid_q <= 1'b0;
      inj_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      im_mode_q   <= im_mode_d;
      mode_q      <= mode_d;
      nmi_q       <= nmi_d;
      v_q         <= v_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      target_q    <= target_d;
      bus_req_q   <= bus_req_d;
      inj_valid_q <= inj_valid_d;
      inj_op_q    <= inj_op_d;
    end
  end

  always_comb begin
    bus_op   = OP_INTA;
    bus_addr = '0;
    case (state_q)
      ST_PUSH:   bus_op = OP_PUSH;
      ST_VEC_LO: begin
        bus_op   = OP_MEMRD;
        bus_addr = vec_addr;
      end
      ST_VEC_HI: begin
        bus_op   = OP_MEMRD;
        bus_addr = vec_addr + 16'd1;
      end
      default: ;
    endcase
  end

  assign bus_req   = bus_req_q;
  assign pc_load   = (state_q == ST_LOAD);
  assign pc_new    = pc_load ? (use_vec ? {hi_q, lo_q} : target_q) : '0;
  assign inj_valid = inj_valid_q;
  assign inj_op    = inj_op_q;
  assign busy      = (state_q != ST_IDLE) || inj_valid_q;
  assign im_mode   = im_mode_q;

endmodule
